// File: rtl/fifo_uart_tx_if.sv
// Bundle between the fifo head and its UART drain stage.
// master = fifo side, slave = serialiser side.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_empty;
    logic             fifo_read;
    logic             tx;
    logic             busy;

    modport master (
        output fifo_data,
        output fifo_empty,
        input  fifo_read,
        input  tx,
        input  busy
    );

    modport slave (
        input  fifo_data,
        input  fifo_empty,
        output fifo_read,
        output tx,
        output busy
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Fifo drain stage: pops one word per frame and sends it as async UART.
// Optional even parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic [WIDTH-1:0] i_fifo_data,
    input  logic             i_fifo_empty,
    output logic             o_fifo_read,
    output logic             o_tx,
    output logic             o_busy
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("STOP_BITS must be 1 or 2");
        end
    endgenerate

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP
    } state_t;
`endif

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [BIT_W-1:0]  r_bit;
    logic [WIDTH-1:0]  r_shift;
    logic              r_tx;
    logic              r_busy;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              r_parity;
`endif

    logic w_bit_end;
    logic w_last_stop;
    logic w_pop;

    assign w_bit_end   = (r_baud == BAUD_LAST);
    assign w_last_stop = (r_state == STOP) && w_bit_end &&
                         (r_bit == STOP_LAST);
    // Held off during reset so an aborted frame never pops a word.
    assign w_pop       = i_nrst && !i_fifo_empty &&
                         ((r_state == IDLE) || w_last_stop);

    assign o_fifo_read = w_pop;
    assign o_tx        = r_tx;
    assign o_busy      = r_busy;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE || w_bit_end) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_bit <= '0;
                    if (w_pop) begin
                        r_shift  <= i_fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        r_parity <= ^i_fifo_data;
`endif
                        r_state  <= START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                START: begin
                    if (w_bit_end) begin
                        r_state <= DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end
                end

                DATA: begin
                    if (w_bit_end) begin
                        if (r_bit == DATA_LAST) begin
                            r_bit   <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end
                end

`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_state <= STOP;
                        r_bit   <= '0;
                        r_tx    <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (w_bit_end) begin
                        if (r_bit == STOP_LAST) begin
                            r_bit <= '0;
                            // Chain straight into the next start bit.
                            if (w_pop) begin
                                r_shift  <= i_fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                                r_parity <= ^i_fifo_data;
`endif
                                r_state  <= START;
                                r_tx     <= 1'b0;
                            end else begin
                                r_state  <= IDLE;
                                r_tx     <= 1'b1;
                                r_busy   <= 1'b0;
                            end
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: frame table plus reset/2-stop sequences.
// Expected frames flip with FIFO_UART_TX_PARITY_EN.
module tb_fifo_uart_tx;
    localparam int C0 = 4;
    localparam int C1 = 2;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB0 = 1 + 8 + P + 1;
    localparam int NB1 = 1 + 8 + P + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_uart_tx_if #(.WIDTH(8)) if0 ();
    fifo_uart_tx_if #(.WIDTH(8)) if1 ();

    fifo_uart_tx #(
        .WIDTH(8), .CLKS_PER_BIT(C0), .STOP_BITS(1)
    ) dut0 (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_fifo_data  (if0.fifo_data),
        .i_fifo_empty (if0.fifo_empty),
        .o_fifo_read  (if0.fifo_read),
        .o_tx         (if0.tx),
        .o_busy       (if0.busy)
    );

    fifo_uart_tx #(
        .WIDTH(8), .CLKS_PER_BIT(C1), .STOP_BITS(2)
    ) dut1 (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_fifo_data  (if1.fifo_data),
        .i_fifo_empty (if1.fifo_empty),
        .o_fifo_read  (if1.fifo_read),
        .o_tx         (if1.tx),
        .o_busy       (if1.busy)
    );

    // Simple fifo models feeding each DUT
    logic [7:0] m0 [32];
    logic [7:0] m1 [32];
    int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
    int pops0 = 0, pops1 = 0;
    int bad_empty = 0;

    assign if0.fifo_data  = m0[rd0 % 32];
    assign if0.fifo_empty = (rd0 == wr0);
    assign if1.fifo_data  = m1[rd1 % 32];
    assign if1.fifo_empty = (rd1 == wr1);

    always @(posedge clk) begin
        if (if0.fifo_read) begin
            rd0   <= rd0 + 1;
            pops0 <= pops0 + 1;
        end
        if (if1.fifo_read) begin
            rd1   <= rd1 + 1;
            pops1 <= pops1 + 1;
        end
    end

    always @(negedge clk) begin
        if ((if0.fifo_read && if0.fifo_empty) ||
            (if1.fifo_read && if1.fifo_empty))
            bad_empty <= bad_empty + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h",
                      name, act, exp);
    endtask

    function automatic logic tx_of(input int w);
        return (w != 0) ? if1.tx : if0.tx;
    endfunction

    function automatic logic busy_of(input int w);
        return (w != 0) ? if1.busy : if0.busy;
    endfunction

    function automatic logic rd_of(input int w);
        return (w != 0) ? if1.fifo_read : if0.fifo_read;
    endfunction

    task automatic push(input int w, input logic [7:0] d);
        if (w == 0) begin
            m0[wr0 % 32] = d;
            wr0++;
        end else begin
            m1[wr1 % 32] = d;
            wr1++;
        end
    endtask

    task automatic wait_pop(input int w, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rd_of(w)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Captures one frame, one sample per cycle, starting the cycle after a pop.
    task automatic read_frame(input int w, input int nb, input int cpb,
                              output logic [11:0] bits,
                              output logic stable, output logic early,
                              output logic end_pop, output logic busy_ok);
        logic t;
        bits = '0;
        stable = 1'b1;
        early = 1'b0;
        end_pop = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                t = tx_of(w);
                if (c == 0) bits[i] = t;
                else if (t !== bits[i]) stable = 1'b0;
                if (busy_of(w) !== 1'b1) busy_ok = 1'b0;
                if (i == nb - 1 && c == cpb - 1) end_pop = rd_of(w);
                else if (rd_of(w)) early = 1'b1;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  word;
        logic [11:0] exp;
        logic        chain;
    } vec_t;

    vec_t tab [5];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok, st, early, endp, bok, any;
        logic [11:0] bits;
        logic [11:0] exp_96, exp_80, exp_01b;

        // Frame bit i = i-th bit on the line (bit 0 = start)
`ifdef FIFO_UART_TX_PARITY_EN
        tab[0] = '{8'hA5, 12'h54A, 1'b0};
        tab[1] = '{8'h00, 12'h400, 1'b1};
        tab[2] = '{8'hFF, 12'h5FE, 1'b1};
        tab[3] = '{8'h3C, 12'h478, 1'b0};
        tab[4] = '{8'h01, 12'h602, 1'b0};
        exp_96  = 12'h52C;
        exp_80  = 12'hF00;
        exp_01b = 12'hE02;
`else
        tab[0] = '{8'hA5, 12'h34A, 1'b0};
        tab[1] = '{8'h00, 12'h200, 1'b1};
        tab[2] = '{8'hFF, 12'h3FE, 1'b1};
        tab[3] = '{8'h3C, 12'h278, 1'b0};
        tab[4] = '{8'h01, 12'h202, 1'b0};
        exp_96  = 12'h32C;
        exp_80  = 12'h700;
        exp_01b = 12'h602;
`endif

        #12;
        check("rst_tx0", 32'(if0.tx), 32'd1);
        check("rst_busy0", 32'(if0.busy), 32'd0);
        check("rst_read0", 32'(if0.fifo_read), 32'd0);
        check("rst_tx1", 32'(if1.tx), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        any = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (if0.tx !== 1'b1 || if0.busy !== 1'b0 ||
                if0.fifo_read !== 1'b0 || if1.tx !== 1'b1 ||
                if1.busy !== 1'b0 || if1.fifo_read !== 1'b0)
                any = 1'b1;
        end
        check("idle_100", 32'(any), 32'd0);

        for (int i = 0; i < 5; i++) begin
            if (i == 0 || !tab[i-1].chain) begin
                @(posedge clk);
                #1;
                for (int j = i; j < 5; j++) begin
                    push(0, tab[j].word);
                    if (!tab[j].chain) break;
                end
                wait_pop(0, ok);
                check($sformatf("pop_%0d", i), 32'(ok), 32'd1);
            end
            read_frame(0, NB0, C0, bits, st, early, endp, bok);
            check($sformatf("frame_%0d", i), 32'(bits), 32'(tab[i].exp));
            check($sformatf("stable_%0d", i), 32'(st), 32'd1);
            check($sformatf("early_pop_%0d", i), 32'(early), 32'd0);
            check($sformatf("chain_pop_%0d", i), 32'(endp),
                  32'(tab[i].chain));
            check($sformatf("busy_%0d", i), 32'(bok), 32'd1);
            if (!tab[i].chain) begin
                @(negedge clk);
                check($sformatf("idle_busy_%0d", i), 32'(if0.busy), 32'd0);
                check($sformatf("idle_tx_%0d", i), 32'(if0.tx), 32'd1);
            end
        end
        check("pops_table", 32'(pops0), 32'd5);

        // Reset 10 cycles into a frame, with another word waiting
        @(posedge clk);
        #1;
        push(0, 8'hA5);
        push(0, 8'h96);
        wait_pop(0, ok);
        check("pop_abort", 32'(ok), 32'd1);
        repeat (10) @(negedge clk);
        check("pre_rst_tx", 32'(if0.tx), 32'd0);
        check("pre_rst_busy", 32'(if0.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(if0.tx), 32'd1);
        check("mid_rst_busy", 32'(if0.busy), 32'd0);
        check("mid_rst_read", 32'(if0.fifo_read), 32'd0);
        repeat (3) @(posedge clk);
        check("rst_no_pop", 32'(pops0), 32'd6);
        #1 rst_n = 1'b1;
        wait_pop(0, ok);
        check("pop_after_rst", 32'(ok), 32'd1);
        read_frame(0, NB0, C0, bits, st, early, endp, bok);
        check("frame_after_rst", 32'(bits), 32'(exp_96));
        check("end_after_rst", 32'(endp), 32'd0);
        @(negedge clk);
        check("pops_after_rst", 32'(pops0), 32'd7);

        // Two stop bits at 2 clocks per bit, back to back
        @(posedge clk);
        #1;
        push(1, 8'h80);
        push(1, 8'h01);
        wait_pop(1, ok);
        check("pop_2stop", 32'(ok), 32'd1);
        read_frame(1, NB1, C1, bits, st, early, endp, bok);
        check("frame_2stop_a", 32'(bits), 32'(exp_80));
        check("early_2stop_a", 32'(early), 32'd0);
        check("chain_2stop_a", 32'(endp), 32'd1);
        read_frame(1, NB1, C1, bits, st, early, endp, bok);
        check("frame_2stop_b", 32'(bits), 32'(exp_01b));
        check("early_2stop_b", 32'(early), 32'd0);
        check("end_2stop_b", 32'(endp), 32'd0);
        check("busy_2stop", 32'(bok), 32'd1);
        @(negedge clk);
        check("idle_2stop", 32'(if1.busy), 32'd0);
        check("pops_2stop", 32'(pops1), 32'd2);

        check("read_when_empty", 32'(bad_empty), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
